mux4_rr_arbiter: RTL and testbench



---
 rtl/mux4_rr_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter with bounded hold that drives the select lines of a shared
// 4:1 one-bit mux and returns a registered sample of the granted input.
module mux4_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       i0,
    input  logic       i1,
    input  logic       i2,
    input  logic       i3,
    output logic [3:0] gnt,
    output logic       s0,
    output logic       s1,
    output logic       busy,
    output logic       y,
    output logic       y_valid
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

    // Bit 2 flags a hit; bits 1:0 hold the first requester at or after ptr, circularly.
    function automatic logic [2:0] rr_pick(input logic [3:0] req_v, input logic [1:0] ptr);
        logic [1:0] idx;
        logic [2:0] pick;
        pick = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx  = ptr + 2'(k);
            pick = req_v[idx] ? {1'b1, idx} : pick;
        end
        return pick;
    endfunction

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    state_t           r_state, w_state_nxt;
    logic [1:0]       r_owner, w_owner_nxt;
    logic [3:0]       r_gnt,   w_gnt_nxt;
    logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
    logic [1:0]       r_ptr,   w_ptr_nxt;
    logic             r_busy,  w_busy_nxt;
    logic             r_y;
    logic             r_y_valid;
    logic [2:0]       w_pick;
    logic [1:0]       w_rel_ptr;
    logic             w_release;
    logic             w_mux;

    assign w_rel_ptr = r_owner + 2'd1;

    // Next-state, grant and pointer decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_gnt_nxt   = r_gnt;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        w_release   = 1'b0;
        w_pick      = 3'b000;
        case (r_state)
            ST_IDLE: begin
                w_pick = rr_pick(req, r_ptr);
                if (w_pick[2]) begin
                    w_state_nxt = ST_GRANT;
                    w_owner_nxt = w_pick[1:0];
                    w_gnt_nxt   = onehot4(w_pick[1:0]);
                    w_cnt_nxt   = CNT_ZERO;
                end else begin
                    w_gnt_nxt   = 4'b0000;
                end
            end
            ST_GRANT: begin
                w_release = !req[r_owner] || (r_cnt == HOLD_LAST);
                if (w_release) begin
                    // Re-arbitrate on the release edge so a waiting requester gets no bubble.
                    w_ptr_nxt = w_rel_ptr;
                    w_pick    = rr_pick(req, w_rel_ptr);
                    w_cnt_nxt = CNT_ZERO;
                    if (w_pick[2]) begin
                        w_owner_nxt = w_pick[1:0];
                        w_gnt_nxt   = onehot4(w_pick[1:0]);
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_gnt_nxt   = 4'b0000;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = 4'b0000;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
        w_busy_nxt = (w_state_nxt == ST_GRANT);
    end

    // Arbitration state, owner/select, hold counter and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_owner <= 2'd0;
            r_gnt   <= 4'b0000;
            r_cnt   <= CNT_ZERO;
            r_ptr   <= 2'd0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_gnt   <= w_gnt_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // Model of the shared mux as seen through the registered select.
    always_comb begin
        w_mux = 1'b0;
        case (r_owner)
            2'd0:    w_mux = i0;
            2'd1:    w_mux = i1;
            2'd2:    w_mux = i2;
            2'd3:    w_mux = i3;
            default: w_mux = 1'b0;
        endcase
    end

    // Sample the selected input only while a grant was active before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y       <= 1'b0;
            r_y_valid <= 1'b0;
        end else begin
            r_y_valid <= r_busy;
            if (r_busy) begin
                r_y <= w_mux;
            end else begin
                r_y <= r_y;
            end
        end
    end

    assign gnt     = r_gnt;
    assign s0      = r_owner[1];
    assign s1      = r_owner[0];
    assign busy    = r_busy;
    assign y       = r_y;
    assign y_valid = r_y_valid;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: directed vectors push expected outputs,
// a monitor pops and compares them after each rising edge.
module tb_mux4_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       i0, i1, i2, i3;
    logic [3:0] gnt;
    logic       s0, s1, busy, y, y_valid;

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .i0      (i0),
        .i1      (i1),
        .i2      (i2),
        .i3      (i3),
        .gnt     (gnt),
        .s0      (s0),
        .s1      (s1),
        .busy    (busy),
        .y       (y),
        .y_valid (y_valid)
    );

    string      name_q[$];
    logic [8:0] vec_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic       t_busy, t_y;
    logic [1:0] t_sel;
    logic [3:0] oh;
    string      mon_name;
    logic [8:0] mon_vec;

    task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %b want %b (gnt,s0,s1,busy,y,y_valid)", nm, act, exp_v);
        end
    endtask

    // Drive one cycle of inputs; expected outputs after the next rising edge.
    // y/y_valid follow from the previously expected busy and select.
    task automatic step(input logic [3:0] r, input logic [3:0] d, input logic [3:0] eg,
                        input logic [1:0] esel, input logic eb, input string nm);
        logic ey;
        @(negedge clk);
        req = r;
        {i3, i2, i1, i0} = d;
        ey = t_busy ? d[t_sel] : t_y;
        name_q.push_back(nm);
        vec_q.push_back({eg, esel, eb, ey, t_busy});
        t_busy = eb;
        t_sel  = esel;
        t_y    = ey;
    endtask

    // Monitor: compare one expected entry per clock, away from the edge.
    always @(posedge clk) begin
        #3;
        if (vec_q.size() > 0) begin
            mon_name = name_q.pop_front();
            mon_vec  = vec_q.pop_front();
            chk(mon_name, {gnt, s0, s1, busy, y, y_valid}, mon_vec);
        end
    end

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        {i3, i2, i1, i0} = 4'b0000;
        t_busy = 1'b0;
        t_sel  = 2'd0;
        t_y    = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_values", {gnt, s0, s1, busy, y, y_valid}, 9'd0);
        rst_n = 1'b1;

        // Get a grant, move it to requester 1, then reset mid-grant.
        step(4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b1, "A1_grant0");
        step(4'b0010, 4'b0001, 4'b0010, 2'd1, 1'b1, "A2_handoff1");
        step(4'b0010, 4'b0011, 4'b0010, 2'd1, 1'b1, "A3_hold1_y1");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_mid_grant", {gnt, s0, s1, busy, y, y_valid}, 9'd0);
        t_busy = 1'b0;
        t_sel  = 2'd0;
        t_y    = 1'b0;
        req    = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;

        // Pointer restarts at 0 after reset; then the single-request i2 case.
        step(4'b1001, 4'b0000, 4'b0001, 2'd0, 1'b1, "B1_ptr0_after_reset");
        step(4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, "B2_grant2");
        step(4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, "B3_y_from_i2");
        step(4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b0, "B4_idle_sel_held");
        step(4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, "B5_idle_y_held");

        // Select mapping: each requester alone, with only its own data bit set.
        for (int k = 0; k < 4; k++) begin
            oh = 4'b0001 << k;
            step(oh, oh, oh, 2'(k), 1'b1, $sformatf("C_grant%0d", k));
            step(oh, oh, oh, 2'(k), 1'b1, $sformatf("C_hold%0d", k));
        end
        step(4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b0, "D_idle");

        // Fairness: all requesting, owners 0,1,2,3,0 for 8 cycles each, no gap.
        for (int r = 0; r < 5; r++) begin
            oh = 4'b0001 << (r % 4);
            for (int c = 0; c < 8; c++) begin
                step(4'b1111, 4'b1010, oh, 2'(r % 4), 1'b1, $sformatf("D_fair_r%0d_c%0d", r, c));
            end
        end

        // Early release: owner 1 drops after 3 cycles while 3 keeps asking.
        step(4'b1010, 4'b1010, 4'b0010, 2'd1, 1'b1, "E_rotate_to1");
        step(4'b1010, 4'b1010, 4'b0010, 2'd1, 1'b1, "E_hold1_a");
        step(4'b1010, 4'b1010, 4'b0010, 2'd1, 1'b1, "E_hold1_b");
        step(4'b1000, 4'b1010, 4'b1000, 2'd3, 1'b1, "E_handoff3");
        step(4'b1000, 4'b1010, 4'b1000, 2'd3, 1'b1, "E_hold3");

        // Lone owner 0 for 20 cycles: re-granted silently, busy never drops.
        for (int c = 0; c < 20; c++) begin
            step(4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b1, $sformatf("F_lone0_c%0d", c));
        end
        step(4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b0, "F_idle");
        step(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, "F_y_valid_fall");

        // Pointer is 1 after owner 0 released: 3 beats 0.
        step(4'b1001, 4'b0000, 4'b1000, 2'd3, 1'b1, "G_ptr1_picks3");
        step(4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1, "G_handoff0");
        step(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, "G_idle");

        for (int w = 0; w < 10; w++) begin
            if (vec_q.size() != 0) @(posedge clk);
        end
        #4;
        chk("scoreboard_drain", 9'(vec_q.size()), 9'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
